// File: rtl/twenty_bit_shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier slice.
//   DEF_WIDTH   : operand width (must match the twenty_bit_adder instance)
//   DEF_COUNT_W : iteration counter width, covers 0..DEF_WIDTH-1
//   LAST_ITER   : counter value of the final shift-and-add iteration
//   state_t     : controller states (IDLE/BUSY/DONE, 2-bit encoding)
package twenty_bit_shift_add_multiplier_pkg;

    localparam int unsigned DEF_WIDTH   = 20;
    localparam int unsigned DEF_COUNT_W = 5;
    localparam int unsigned LAST_ITER   = 19;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/twenty_bit_shift_add_multiplier_adder.sv
// twenty_bit_adder: purely combinational 20-bit ripple-carry adder.
// Ports:
//   a, b : 20-bit unsigned addends
//   sum  : 20-bit sum
//   cout : carry out of bit 19
module twenty_bit_adder
    import twenty_bit_shift_add_multiplier_pkg::*;
(
    input  logic [DEF_WIDTH-1:0] a,
    input  logic [DEF_WIDTH-1:0] b,
    output logic [DEF_WIDTH-1:0] sum,
    output logic                 cout
);

    logic [DEF_WIDTH:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        for (int unsigned i = 0; i < DEF_WIDTH; i++) begin
            sum[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[DEF_WIDTH];
    end

endmodule

// File: rtl/twenty_bit_shift_add_multiplier.sv
// twenty_bit_shift_add_multiplier: sequential unsigned 20x20 -> 40-bit
// multiplier, one multiplier bit retired per cycle through a single shared
// ripple adder.
// Ports:
//   clk, rst_n              : clock (rising edge), synchronous active-low reset
//   in_valid / in_ready     : operand handshake (ready only in IDLE)
//   multiplicand, multiplier: 20-bit unsigned operands
//   out_valid / out_ready   : product handshake (valid only in DONE)
//   product                 : 40-bit registered product, held while in DONE
module twenty_bit_shift_add_multiplier
    import twenty_bit_shift_add_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned COUNT_W = DEF_COUNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    state_t             state;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [COUNT_W-1:0] count;

    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic [WIDTH:0]     step;   // {carry, partial high word} before the shift

    twenty_bit_adder u_adder (
        .a    (hi),
        .b    (a),
        .sum  (sum),
        .cout (cout)
    );

    // Add the multiplicand only when the current multiplier bit is set; the
    // carry is kept as the 21st bit so it lands in hi[MSB] after the shift.
    always_comb begin
        step = {1'b0, hi};
        if (lo[0]) begin
            step = {cout, sum};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a         <= '0;
            hi        <= '0;
            lo        <= '0;
            count     <= '0;
            product   <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        a        <= multiplicand;
                        lo       <= multiplier;
                        hi       <= '0;
                        count    <= '0;
                        in_ready <= 1'b0;
                        if (multiplicand == '0 || multiplier == '0) begin
                            product   <= '0;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            state <= S_BUSY;
                        end
                    end
                end

                S_BUSY: begin
                    hi    <= step[WIDTH:1];
                    lo    <= {step[0], lo[WIDTH-1:1]};
                    count <= count + COUNT_W'(1);
                    // Product is loaded with the same shifted value that goes
                    // into {hi,lo}, so it is already final when out_valid rises.
                    if (count == COUNT_W'(LAST_ITER)) begin
                        product   <= {step, lo[WIDTH-1:1]};
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_twenty_bit_shift_add_multiplier.sv
// Self-checking bench for twenty_bit_shift_add_multiplier.
module tb_twenty_bit_shift_add_multiplier;
    import twenty_bit_shift_add_multiplier_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] multiplicand;
    logic [19:0] multiplier;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] product;

    twenty_bit_shift_add_multiplier #(
        .WIDTH   (20),
        .COUNT_W (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [19:0]  a;
        logic [19:0]  b;
        logic [39:0]  prod;
        int unsigned  lat;    // edges after the accept edge until out_valid
        bit           trace;  // compare hi against a bit-level model each step
    } vec_t;

    vec_t          vecs [8];
    logic [39:0]   sb [$];
    int unsigned   n_pass;
    int unsigned   n_total;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One job with out_ready held high; expected product goes through the
    // scoreboard queue and is popped when out_valid is observed.
    task automatic run_job(input logic [19:0] ta, input logic [19:0] tb_,
                           input logic [39:0] tp, input int unsigned exp_lat,
                           input bit trace);
        int unsigned lat;
        logic [19:0] mh;
        logic [19:0] ml;
        logic [20:0] s;
        logic [39:0] exp_p;
        out_ready = 1'b1;
        check("idle_in_ready", 64'(in_ready), 64'd1);
        multiplicand = ta;
        multiplier   = tb_;
        in_valid     = 1'b1;
        sb.push_back(tp);
        tick;
        in_valid = 1'b0;
        check("busy_in_ready", 64'(in_ready), 64'd0);
        mh  = '0;
        ml  = tb_;
        lat = 0;
        while (!out_valid && lat < 64) begin
            tick;
            lat++;
            if (trace) begin
                s  = ml[0] ? ({1'b0, mh} + {1'b0, ta}) : {1'b0, mh};
                mh = s[20:1];
                ml = {s[0], ml[19:1]};
                check("hi_iter", 64'(dut.hi), 64'(mh));
            end
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("out_valid", 64'(out_valid), 64'd1);
        exp_p = (sb.size() > 0) ? sb.pop_front() : 40'h0;
        check("product", 64'(product), 64'(exp_p));
        tick;
        check("handoff_valid", 64'(out_valid), 64'd0);
        check("handoff_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        int unsigned lat;
        logic [39:0] exp_p;
        n_pass       = 0;
        n_total      = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        multiplicand = '0;
        multiplier   = '0;

        vecs[0] = '{a: 20'd111,    b: 20'd222,    prod: 40'd24642,        lat: 20, trace: 1'b0};
        vecs[1] = '{a: 20'd1000,   b: 20'd1000,   prod: 40'h00000F4240,   lat: 20, trace: 1'b0};
        vecs[2] = '{a: 20'hFFFFF,  b: 20'hFFFFF,  prod: 40'hFFFFE00001,   lat: 20, trace: 1'b1};
        vecs[3] = '{a: 20'd0,      b: 20'd12345,  prod: 40'd0,            lat: 0,  trace: 1'b0};
        vecs[4] = '{a: 20'd7,      b: 20'd0,      prod: 40'd0,            lat: 0,  trace: 1'b0};
        vecs[5] = '{a: 20'd1,      b: 20'd1,      prod: 40'd1,            lat: 20, trace: 1'b0};
        vecs[6] = '{a: 20'hFFFFF,  b: 20'd1,      prod: 40'h00000FFFFF,   lat: 20, trace: 1'b0};
        vecs[7] = '{a: 20'h80000,  b: 20'h80000,  prod: 40'h4000000000,   lat: 20, trace: 1'b0};

        tick;
        tick;
        rst_n = 1'b1;
        tick;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_product", 64'(product), 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_job(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].lat, vecs[i].trace);
        end

        // Back-pressure: product must hold while out_ready is low, and
        // operand pulses during BUSY/DONE must be ignored.
        out_ready    = 1'b0;
        multiplicand = 20'd3;
        multiplier   = 20'd5;
        in_valid     = 1'b1;
        sb.push_back(40'd15);
        tick;
        in_valid = 1'b0;
        check("bp_busy_ready", 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 64) begin
            in_valid     = (lat == 5);
            multiplicand = 20'd9;
            multiplier   = 20'd9;
            tick;
            lat++;
        end
        in_valid = 1'b0;
        check("bp_latency", 64'(lat), 64'd20);
        exp_p = (sb.size() > 0) ? sb.pop_front() : 40'h0;
        for (int i = 0; i < 10; i++) begin
            in_valid     = (i % 3 == 0);
            multiplicand = 20'd11;
            multiplier   = 20'd13;
            tick;
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_product", 64'(product), 64'(exp_p));
            check("bp_hold_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_release_ready", 64'(in_ready), 64'd1);
        check("bp_sb_empty", 64'(sb.size()), 64'd0);

        // Reset mid-job: abort with clean state, then a fresh job.
        multiplicand = 20'd1000;
        multiplier   = 20'd1000;
        in_valid     = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
        end
        check("pre_rst_busy", 64'(dut.state), 64'(S_BUSY));
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        check("abort_state", 64'(dut.state), 64'(S_IDLE));
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_product", 64'(product), 64'd0);
        check("abort_hi", 64'(dut.hi), 64'd0);
        run_job(20'd2, 20'd3, 40'd6, 20, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
